axi_burst_addr_gen: RTL and testbench

//  Consumes one AXI AW or AR request (axi_aw_ar_t) and expands it into per-beat addresses.

---
 rtl/axi_types_pkg.sv | 34 +++
 rtl/axi_next_addr.sv | 32 +++
 rtl/axi_burst_addr_gen.sv | 123 ++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_types_pkg.sv
// Shared AXI widths, burst encodings and request/beat records for the slave-port
// address path.
package axi_types_pkg;

  localparam int AXI_ID_W     = 4;
  localparam int AXI_ADDR_W   = 32;
  localparam int AXI_DATA_W   = 64;
  localparam int AXI_STRB_W   = AXI_DATA_W / 8;
  localparam int AXI_MAX_SIZE = $clog2(AXI_STRB_W);
  localparam int AXI_4KB      = 4096;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            qos;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } axi_aw_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            idx;
    logic                  last;
  } axi_beat_t;

endpackage

// File: rtl/axi_next_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared with the
// R/W beat engines.
module axi_next_addr
  import axi_types_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic [ADDR_W-1:0] wrap_lower,
  input  logic [ADDR_W-1:0] wrap_bytes,
  output logic [ADDR_W-1:0] nxt
);

  logic [ADDR_W-1:0] n_bytes;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] incr;

  always_comb begin
    n_bytes = ADDR_W'(1) << size;
    aligned = addr & ~(n_bytes - ADDR_W'(1));
    incr    = aligned + n_bytes;
    nxt     = incr;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (incr == wrap_lower + wrap_bytes) ? wrap_lower : incr;
      default:     nxt = incr;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AW/AR request into per-beat addresses, one burst in flight, and
// flags illegal or 4KB-crossing requests in the accept cycle.
module axi_burst_addr_gen
  import axi_types_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  axi_aw_ar_t        req,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ID_W-1:0]   beat_id,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [7:0]        beat_idx,
  output logic              beat_last,
  output logic              busy,
  output logic              err_illegal,
  output logic              err_4k
);

  localparam int MAX_SIZE   = $clog2(DATA_W / 8);
  localparam int PAGE_SHIFT = $clog2(AXI_4KB);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        state;
  axi_beat_t         cur;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ADDR_W-1:0] wrap_lower_q;
  logic [ADDR_W-1:0] wrap_bytes_q;

  logic              accept;
  logic              illegal;
  logic              cross_4k;
  logic [1:0]        eff_burst;
  logic [ADDR_W-1:0] n_bytes;
  logic [ADDR_W-1:0] aligned0;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] nxt;

  always_comb begin
    accept    = req_valid & req_ready & ~rst;
    illegal   = (req.burst == 2'b11) || (int'(req.size) > MAX_SIZE) ||
                ((req.burst == BURST_WRAP) && !(req.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    eff_burst = illegal ? BURST_INCR : req.burst;
    n_bytes   = ADDR_W'(1) << req.size;
    aligned0  = req.addr & ~(n_bytes - ADDR_W'(1));
    // beat 0 keeps the unaligned address; later beats are size-aligned
    last_addr = (req.len == 8'd0) ? req.addr : aligned0 + (ADDR_W'(req.len) << req.size);
    cross_4k  = (eff_burst == BURST_INCR) &&
                ((req.addr >> PAGE_SHIFT) != (last_addr >> PAGE_SHIFT));
    wrap_bytes = ADDR_W'({1'b0, req.len} + 9'd1) << req.size;
  end

  assign req_ready   = (state == S_IDLE);
  assign beat_valid  = (state == S_BURST);
  assign busy        = (state == S_BURST);
  assign beat_id     = cur.id;
  assign beat_addr   = cur.addr;
  assign beat_idx    = cur.idx;
  assign beat_last   = beat_valid & (cur.idx == len_q);
  assign err_illegal = accept & illegal;
  assign err_4k      = accept & cross_4k;

  axi_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .addr       (cur.addr),
    .size       (size_q),
    .burst      (burst_q),
    .wrap_lower (wrap_lower_q),
    .wrap_bytes (wrap_bytes_q),
    .nxt        (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cur          <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      wrap_lower_q <= '0;
      wrap_bytes_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_BURST;
            cur.id       <= req.id;
            cur.addr     <= req.addr;
            cur.idx      <= 8'd0;
            cur.last     <= (req.len == 8'd0);
            len_q        <= req.len;
            size_q       <= req.size;
            burst_q      <= eff_burst;
            wrap_bytes_q <= wrap_bytes;
            wrap_lower_q <= req.addr & ~(wrap_bytes - ADDR_W'(1));
          end
        end
        default: begin
          if (beat_ready) begin
            if (beat_last) begin
              state <= S_IDLE;
            end else begin
              cur.addr <= nxt;
              cur.idx  <= cur.idx + 8'd1;
              cur.last <= (cur.idx + 8'd1 == len_q);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench: directed vector table, back-pressure/reset sequence and
// randomized bursts against an arithmetic address model.
module tb_axi_burst_addr_gen;
  import axi_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  axi_aw_ar_t  req;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        busy;
  logic        err_illegal;
  logic        err_4k;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr [256];

  always #5 clk = ~clk;

  axi_burst_addr_gen #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_addr(beat_addr), .beat_idx(beat_idx), .beat_last(beat_last), .busy(busy),
    .err_illegal(err_illegal), .err_4k(err_4k)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        ill;
    logic        e4k;
    logic [31:0] a [4];
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic model_illegal(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd3) ||
           (burst == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
  endfunction

  // Beat k address from the burst rules, written as offset arithmetic
  function automatic logic [31:0] model_addr(input logic [31:0] a0, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int k);
    logic [31:0] n, al, w, lower;
    logic [1:0]  eb;
    eb = model_illegal(len, size, burst) ? 2'b01 : burst;
    n  = 32'd1 << size;
    al = (a0 / n) * n;
    if (k == 0 || eb == 2'b00) return a0;
    if (eb == 2'b10) begin
      w     = (32'(len) + 1) * n;
      lower = (a0 / w) * w;
      return lower + ((al - lower + 32'(k) * n) % w);
    end
    return al + 32'(k) * n;
  endfunction

  function automatic logic [47:0] pack_beat(input logic v, input logic [3:0] id,
      input logic [31:0] a, input logic [7:0] idx, input logic last, input logic rr,
      input logic bz);
    return {v, id, a, idx, last, rr, bz};
  endfunction

  task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic ill, input logic e4k,
                           input int stall_max);
    int s;
    req_valid  = 1'b1;
    req        = '0;
    req.id     = id;
    req.addr   = addr;
    req.len    = len;
    req.size   = size;
    req.burst  = burst;
    req.qos    = 4'(($urandom));
    beat_ready = 1'b0;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, " err_illegal"}, 64'(err_illegal), 64'(ill));
    chk({tag, " err_4k"}, 64'(err_4k), 64'(e4k));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req       = '0;
    for (int k = 0; k <= int'(len); k++) begin
      s = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      repeat (s) begin
        beat_ready = 1'b0;
        #1;
        chk($sformatf("%s stall beat%0d", tag, k),
            64'({beat_valid, beat_id, beat_addr, beat_idx, beat_last, req_ready, busy,
                 err_illegal, err_4k}),
            64'({pack_beat(1'b1, id, exp_addr[k], 8'(k), k == int'(len), 1'b0, 1'b1), 2'b00}));
        @(posedge clk); #1;
      end
      beat_ready = 1'b1;
      #1;
      chk($sformatf("%s beat%0d", tag, k),
          64'({beat_valid, beat_id, beat_addr, beat_idx, beat_last, req_ready, busy,
               err_illegal, err_4k}),
          64'({pack_beat(1'b1, id, exp_addr[k], 8'(k), k == int'(len), 1'b0, 1'b1), 2'b00}));
      @(posedge clk); #1;
    end
    beat_ready = 1'b0;
    #1;
    chk({tag, " idle after last"}, 64'({req_ready, beat_valid, busy}), 64'(3'b100));
  endtask

  vec_t vecs [8];

  initial begin
    logic [31:0] a0, la;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        ill, e4k;

    vecs[0] = '{32'h1000, 8'd3, 3'd3, 2'b01, 1'b0, 1'b0, '{32'h1000, 32'h1008, 32'h1010, 32'h1018}};
    vecs[1] = '{32'h1018, 8'd3, 3'd3, 2'b10, 1'b0, 1'b0, '{32'h1018, 32'h1000, 32'h1008, 32'h1010}};
    vecs[2] = '{32'h2004, 8'd2, 3'd2, 2'b00, 1'b0, 1'b0, '{32'h2004, 32'h2004, 32'h2004, 32'h0}};
    vecs[3] = '{32'h1003, 8'd2, 3'd2, 2'b01, 1'b0, 1'b0, '{32'h1003, 32'h1004, 32'h1008, 32'h0}};
    vecs[4] = '{32'h3000, 8'd2, 3'd3, 2'b10, 1'b1, 1'b0, '{32'h3000, 32'h3008, 32'h3010, 32'h0}};
    vecs[5] = '{32'h4000, 8'd1, 3'd4, 2'b01, 1'b1, 1'b0, '{32'h4000, 32'h4010, 32'h0, 32'h0}};
    vecs[6] = '{32'h5000, 8'd1, 3'd2, 2'b11, 1'b1, 1'b0, '{32'h5000, 32'h5004, 32'h0, 32'h0}};
    vecs[7] = '{32'h0FF8, 8'd1, 3'd3, 2'b01, 1'b0, 1'b1, '{32'h0FF8, 32'h1000, 32'h0, 32'h0}};

    rst = 1'b1; req_valid = 1'b0; req = '0; beat_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs",
        64'({req_ready, beat_valid, busy, err_illegal, err_4k, beat_id, beat_addr, beat_idx, beat_last}),
        64'({5'b10000, 4'h0, 32'h0, 8'h0, 1'b0}));
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      for (int k = 0; k < 4; k++) exp_addr[k] = vecs[i].a[k];
      run_burst($sformatf("vec%0d", i), 4'(i), vecs[i].addr, vecs[i].len, vecs[i].size,
                vecs[i].burst, vecs[i].ill, vecs[i].e4k, 0);
    end

    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'h0;
    run_burst("wrap32", 4'hA, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0, 1'b1, 0);

    // back-pressure at idx 1, then reset mid-burst at idx 2
    req_valid = 1'b1; req = '0; req.id = 4'h5; req.addr = 32'h6000; req.len = 8'd3;
    req.size = 3'd3; req.burst = 2'b01; beat_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp beat0", 64'({beat_valid, beat_idx, beat_addr}), 64'({1'b1, 8'd0, 32'h6000}));
    @(posedge clk); #1;
    beat_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp hold%0d", c), 64'({beat_valid, beat_idx, beat_addr, beat_last}),
          64'({1'b1, 8'd1, 32'h6008, 1'b0}));
      @(posedge clk); #1;
    end
    beat_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp beat2", 64'({beat_valid, beat_idx, beat_addr}), 64'({1'b1, 8'd2, 32'h6010}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; beat_ready = 1'b0;
    #1;
    chk("mid reset", 64'({beat_valid, req_ready, busy, beat_addr, beat_idx, beat_last}),
        64'({3'b010, 32'h0, 8'h0, 1'b0}));
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      a0    = $urandom;
      len   = (t == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      size  = 3'($urandom_range(0, 4));
      burst = 2'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 2) != 0) len = 8'((1 << $urandom_range(1, 4)) - 1);
      ill = model_illegal(len, size, burst);
      for (int k = 0; k <= int'(len); k++) exp_addr[k] = model_addr(a0, len, size, burst, k);
      la  = exp_addr[len];
      e4k = (ill || burst == 2'b01) && (a0[31:12] != la[31:12]);
      run_burst($sformatf("rnd%0d", t), 4'($urandom), a0, len, size, burst, ill, e4k, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
